// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
// It supports hold, left shift, right shift and parallel load.
// A shared shift counter drives a one-cycle word-complete strobe, so the
// block can be used as a serialiser or as a deserialiser.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             word_valid
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wv_q, wv_d;

    assign mode_s = mode_e'(mode);

    // Next-state selection: clr beats en, and en beats mode
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        wv_d  = 1'b0;
        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (en) begin
            unique case (mode_s)
                MODE_HOLD: ;
                MODE_SHL: q_d = {q_q[WIDTH-2:0], sin};
                MODE_SHR: q_d = {sin, q_q[WIDTH-1:1]};
                MODE_LOAD: begin
                    q_d   = pin;
                    cnt_d = '0;
                end
                default: ;
            endcase
            // Both directions count toward the same word
            if (mode_s == MODE_SHL || mode_s == MODE_SHR) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    wv_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            cnt_q <= '0;
            wv_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

    assign q          = q_q;
    assign sout_msb   = q_q[WIDTH-1];
    assign sout_lsb   = q_q[0];
    assign word_valid = wv_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=8 and WIDTH=5.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, sin;
    logic [1:0] mode;
    logic [7:0] pin;
    logic [4:0] pin5;
    logic [7:0] q;
    logic       sout_msb, sout_lsb, word_valid;
    logic [4:0] q5;
    logic       sout_msb5, sout_lsb5, word_valid5;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [7:0] exp_q8[$];
    logic [4:0] exp_q5[$];

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .sin(sin), .pin(pin), .q(q), .sout_msb(sout_msb),
        .sout_lsb(sout_lsb), .word_valid(word_valid)
    );

    univ_shift_reg #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .sin(sin), .pin(pin5), .q(q5), .sout_msb(sout_msb5),
        .sout_lsb(sout_lsb5), .word_valid(word_valid5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // Advance one edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] ld;
        logic [7:0] m8;
        logic [4:0] m5;
        logic [6:0] lfsr;
        logic       b;
        int unsigned pulses;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00;
        sin = 1'b0; pin = '0; pin5 = '0;
        step();
        chk("reset_q", {24'h0, q}, 32'h0);
        chk("reset_wv", {31'h0, word_valid}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset between edges
        ld = 8'($urandom_range(1, 255));
        en = 1'b1; mode = 2'b11; pin = ld; pin5 = ld[4:0];
        step();
        chk("load_rand", {24'h0, q}, {24'h0, ld});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", {24'h0, q}, 32'h0);
        chk("async_rst_wv", {31'h0, word_valid}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Deserialise left: 1,0,1,1,0,0,1,0 -> 0xB2
        pat = 8'b1011_0010;
        mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            sin = pat[7 - i];
            step();
            chk("deser_wv", {31'h0, word_valid}, {31'h0, (i == 7)});
        end
        chk("deser_q", {24'h0, q}, 32'hB2);
        mode = 2'b00;
        step();
        chk("deser_wv_drop", {31'h0, word_valid}, 32'h0);
        chk("hold_q", {24'h0, q}, 32'hB2);

        // Serialise right: load 0xA5, then shift out LSB first
        mode = 2'b11; pin = 8'hA5; pin5 = 5'h05;
        step();
        chk("ser_load_q", {24'h0, q}, 32'hA5);
        chk("ser_load_wv", {31'h0, word_valid}, 32'h0);
        pat = 8'b1010_0101;
        mode = 2'b10; sin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ser_sout_lsb", {31'h0, sout_lsb}, {31'h0, pat[i]});
            step();
            chk("ser_wv", {31'h0, word_valid}, {31'h0, (i == 7)});
        end
        chk("ser_q_end", {24'h0, q}, 32'h0);

        // Enable / hold gating in the middle of a word
        mode = 2'b01; sin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_wv_a", {31'h0, word_valid}, 32'h0);
        end
        chk("gate_q_a", {24'h0, q}, 32'h0F);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_en0_q", {24'h0, q}, 32'h0F);
            chk("gate_en0_wv", {31'h0, word_valid}, 32'h0);
        end
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("gate_hold_q", {24'h0, q}, 32'h0F);
            chk("gate_hold_wv", {31'h0, word_valid}, 32'h0);
        end
        mode = 2'b01; sin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_wv_b", {31'h0, word_valid}, {31'h0, (i == 3)});
        end
        chk("gate_q_b", {24'h0, q}, 32'hF0);

        // Load mid-word restarts the count
        sin = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_q", {24'h0, q}, 32'h1F);
        mode = 2'b11; pin = 8'h3C;
        step();
        chk("mid_load_q", {24'h0, q}, 32'h3C);
        chk("mid_load_wv", {31'h0, word_valid}, 32'h0);
        mode = 2'b01; sin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_wv", {31'h0, word_valid}, {31'h0, (i == 7)});
        end

        // Clear mid-word, together with load: clear wins
        sin = 1'b1;
        for (int i = 0; i < 3; i++) step();
        clr = 1'b1; mode = 2'b11; pin = 8'hFF; pin5 = 5'h1F;
        step();
        chk("clr_load_q", {24'h0, q}, 32'h0);
        chk("clr_load_wv", {31'h0, word_valid}, 32'h0);
        chk("clr_load_q5", {27'h0, q5}, 32'h0);
        clr = 1'b0;

        // Continuous PRBS stream, WIDTH=8, 24 shifts
        mode = 2'b01; lfsr = 7'h5B; m8 = '0; pulses = 0;
        for (int k = 0; k < 24; k++) begin
            b = lfsr[6];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            sin = b;
            m8 = {m8[6:0], b};
            if ((k % 8) == 7) exp_q8.push_back(m8);
            step();
            chk("stream8_wv", {31'h0, word_valid}, {31'h0, ((k % 8) == 7)});
            chk("stream8_msb", {31'h0, sout_msb}, {31'h0, m8[7]});
            if (word_valid) begin
                pulses++;
                if (exp_q8.size() == 0) chk("stream8_sb_empty", 32'h1, 32'h0);
                else chk("stream8_word", {24'h0, q}, {24'h0, exp_q8.pop_front()});
            end
        end
        chk("stream8_pulses", pulses, 32'd3);
        chk("stream8_left", exp_q8.size(), 32'd0);

        // WIDTH=5, 15 shifts with random direction changes
        clr = 1'b1;
        step();
        clr = 1'b0; m5 = '0; pulses = 0;
        for (int k = 0; k < 15; k++) begin
            b = lfsr[6];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            sin = b;
            if ($urandom_range(0, 1) == 0) begin
                mode = 2'b01; m5 = {m5[3:0], b};
            end else begin
                mode = 2'b10; m5 = {b, m5[4:1]};
            end
            if ((k % 5) == 4) exp_q5.push_back(m5);
            step();
            chk("stream5_wv", {31'h0, word_valid5}, {31'h0, ((k % 5) == 4)});
            chk("stream5_lsb", {31'h0, sout_lsb5}, {31'h0, m5[0]});
            chk("stream5_msb", {31'h0, sout_msb5}, {31'h0, m5[4]});
            if (word_valid5) begin
                pulses++;
                if (exp_q5.size() == 0) chk("stream5_sb_empty", 32'h1, 32'h0);
                else chk("stream5_word", {27'h0, q5}, {27'h0, exp_q5.pop_front()});
            end
        end
        chk("stream5_pulses", pulses, 32'd3);
        chk("stream5_left", exp_q5.size(), 32'd0);

        // Reset mid-word discards the partial word
        mode = 2'b01; sin = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_q", {24'h0, q}, 32'h0);
        chk("midrst_wv", {31'h0, word_valid}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_wv_after", {31'h0, word_valid}, {31'h0, (i == 7)});
        end
        chk("midrst_q_after", {24'h0, q}, 32'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
